// File: rtl/t_ram_arb_pkg.sv
// t_ram_arb shared types: FSM state, requester count, read-owner tag.
// Build option: T_RAM_ARB_RD_REG_EN adds an output register on read return.
package t_ram_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  // one-hot owner of a read beat; all zero means no read
  typedef logic [NREQ-1:0] tag_t;

endpackage

// File: rtl/t_ram_arb_rsp.sv
// Read-return pipeline: carries the owner tag alongside the RAM read.
// T_RAM_ARB_RD_REG_EN defined: extra output stage (L=2); else L=1.
module t_ram_arb_rsp
  import t_ram_arb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  tag_t          rd_tag,
  input  logic [DW-1:0] ram_dout,
  output tag_t          rsp_valid,
  output logic [DW-1:0] rsp_data
);

  tag_t tag_q, tag_d;

  // tag follows the RAM's one-cycle registered read
  always_comb begin
    tag_d = rd_tag;
  end

  // tag register
  always_ff @(posedge clk) begin
    if (sys_rst) tag_q <= '0;
    else         tag_q <= tag_d;
  end

`ifdef T_RAM_ARB_RD_REG_EN
  tag_t          vld_q, vld_d;
  logic [DW-1:0] dat_q, dat_d;

  // capture read data when it arrives, hold it otherwise
  always_comb begin
    vld_d = tag_q;
    dat_d = dat_q;
    if (|tag_q) dat_d = ram_dout;
  end

  // output stage
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // drop any strobe while reset is held
  always_comb begin
    rsp_valid = sys_rst ? '0 : vld_q;
    rsp_data  = dat_q;
  end
`else
  // data straight from the RAM; strobe suppressed under reset
  always_comb begin
    rsp_valid = sys_rst ? '0 : tag_q;
    rsp_data  = sys_rst ? '0 : ram_dout;
  end
`endif

endmodule

// File: rtl/t_ram_arb.sv
// Round-robin arbiter with locked bursts for the shared covariance RAM.
// T_RAM_ARB_RD_REG_EN selects read latency 2 (default 1).
module t_ram_arb
  import t_ram_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ-1:0] req_we,
  input  logic [NREQ-1:0] req_lock,
  input  logic [AW-1:0]   req_addr0,
  input  logic [AW-1:0]   req_addr1,
  input  logic [DW-1:0]   req_wdata0,
  input  logic [DW-1:0]   req_wdata1,
  output logic [NREQ-1:0] rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [NREQ-1:0] gnt;
  tag_t            rd_tag;

  // grant: round-robin when idle, owner-only when locked
  always_comb begin
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid[0] && (!req_valid[1] || !rr_q))
          req_ready = 2'b01;
        else if (req_valid[1])
          req_ready = 2'b10;
      end
      LOCK0:   req_ready = {1'b0, req_valid[0]};
      LOCK1:   req_ready = {req_valid[1], 1'b0};
      default: req_ready = '0;
    endcase
    if (sys_rst) req_ready = '0;
  end

  // next state and round-robin pointer from the granted beat
  always_comb begin
    gnt     = req_valid & req_ready;
    state_d = state_q;
    rr_d    = rr_q;
    unique case (1'b1)
      gnt[0]: begin
        state_d = req_lock[0] ? LOCK0 : IDLE;
        rr_d    = 1'b1;
      end
      gnt[1]: begin
        state_d = req_lock[1] ? LOCK1 : IDLE;
        rr_d    = 1'b0;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // RAM drive from the winner, zero when nobody wins
  always_comb begin
    ram_en   = |gnt;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    rd_tag   = gnt & ~req_we;
    if (gnt[0]) begin
      ram_we   = req_we[0];
      ram_addr = req_addr0;
      ram_din  = req_wdata0;
    end else if (gnt[1]) begin
      ram_we   = req_we[1];
      ram_addr = req_addr1;
      ram_din  = req_wdata1;
    end
  end

  t_ram_arb_rsp #(
    .DW(DW)
  ) u_rsp (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .rd_tag   (rd_tag),
    .ram_dout (ram_dout),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data)
  );

endmodule
